// File: rtl/draw_scheduler_if.sv
// -----------------------------------------------------------------------------
// draw_scheduler_if
// Bundle between the drawing requesters (game FSM side, master) and the shared
// rectangle-fill engine (draw_scheduler, slave).
//   req      per-requester level request, held until the matching done
//   rx0/rx1  per-requester left/right x (inclusive), slice i = [i*W +: W]
//   ry0/ry1  per-requester top/bottom y (inclusive), same packing
//   rcolor   per-requester pixel colour (1 = white, 0 = black)
//   grant    one-hot owner of the engine, zero when idle
//   done     one-cycle pulse on the granted bit at job end
//   busy     engine not idle
//   px/py    current pixel coordinate, pcolor its colour, pwe write strobe
// -----------------------------------------------------------------------------
interface draw_scheduler_if #(
    parameter int NREQ = 3,
    parameter int W    = 11
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] rx0;
    logic [NREQ*W-1:0] rx1;
    logic [NREQ*W-1:0] ry0;
    logic [NREQ*W-1:0] ry1;
    logic [NREQ-1:0]   rcolor;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [W-1:0]      px;
    logic [W-1:0]      py;
    logic              pcolor;
    logic              pwe;

    modport master (
        output req, rx0, rx1, ry0, ry1, rcolor,
        input  grant, done, busy, px, py, pcolor, pwe
    );

    modport slave (
        input  req, rx0, rx1, ry0, ry1, rcolor,
        output grant, done, busy, px, py, pcolor, pwe
    );
endinterface

// File: rtl/draw_scheduler.sv
// -----------------------------------------------------------------------------
// draw_scheduler
// Round-robin arbiter in front of a single rectangle-fill pixel engine. A
// granted requester's rectangle and colour are latched once, then every pixel
// is emitted row-major (x fastest) on the pixel-write port, followed by a
// one-cycle done pulse on the owner's bit.
// Ports:
//   clks   clock, rising edge
//   reset  synchronous, active-high
//   bus    draw_scheduler_if.slave (requests in, grant/done/pixel port out)
// -----------------------------------------------------------------------------
module draw_scheduler #(
    parameter int NREQ = 3,
    parameter int W    = 11
) (
    input  logic            clks,
    input  logic            reset,
    draw_scheduler_if.slave bus
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_r;
    logic [IDXW-1:0] last_r;
    logic [NREQ-1:0] grant_r;
    logic [NREQ-1:0] done_r;
    logic            busy_r;
    logic            pwe_r;
    logic            pcolor_r;
    logic [W-1:0]    px_r;
    logic [W-1:0]    py_r;
    logic [W-1:0]    x0_r;
    logic [W-1:0]    x1_r;
    logic [W-1:0]    y1_r;

    logic [W-1:0]    x0_a_s [NREQ];
    logic [W-1:0]    x1_a_s [NREQ];
    logic [W-1:0]    y0_a_s [NREQ];
    logic [W-1:0]    y1_a_s [NREQ];

    logic            found_s;
    logic [IDXW-1:0] sel_s;
    logic [NREQ-1:0] sel_onehot_s;
    logic            sel_empty_s;
    int              idx_s;

    // Unpack the flat per-requester coordinate buses into indexable arrays.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign x0_a_s[gi] = bus.rx0[gi*W +: W];
        assign x1_a_s[gi] = bus.rx1[gi*W +: W];
        assign y0_a_s[gi] = bus.ry0[gi*W +: W];
        assign y1_a_s[gi] = bus.ry1[gi*W +: W];
    end

    // Round-robin search: first requester at or after last+1, wrapping.
    always_comb begin
        found_s = 1'b0;
        sel_s   = '0;
        idx_s   = 0;
        for (int off = 1; off <= NREQ; off++) begin
            idx_s = int'(last_r) + off;
            if (idx_s >= NREQ) begin
                idx_s = idx_s - NREQ;
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && bus.req[IDXW'(idx_s)]) begin
                found_s = 1'b1;
                sel_s   = IDXW'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
    end

    // One-hot of the winner and empty-rectangle detection (unsigned compare).
    always_comb begin
        sel_onehot_s        = '0;
        sel_onehot_s[sel_s] = 1'b1;
        sel_empty_s = (x1_a_s[sel_s] < x0_a_s[sel_s]) ||
                      (y1_a_s[sel_s] < y0_a_s[sel_s]);
    end

    // Scheduler FSM with registered outputs; px/py hold when pwe is low.
    always_ff @(posedge clks) begin
        if (reset) begin
            state_r  <= IDLE;
            last_r   <= IDXW'(NREQ - 1);
            grant_r  <= '0;
            done_r   <= '0;
            busy_r   <= 1'b0;
            pwe_r    <= 1'b0;
            pcolor_r <= 1'b0;
            px_r     <= '0;
            py_r     <= '0;
            x0_r     <= '0;
            x1_r     <= '0;
            y1_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        grant_r  <= sel_onehot_s;
                        last_r   <= sel_s;
                        x0_r     <= x0_a_s[sel_s];
                        x1_r     <= x1_a_s[sel_s];
                        y1_r     <= y1_a_s[sel_s];
                        pcolor_r <= bus.rcolor[sel_s];
                        px_r     <= x0_a_s[sel_s];
                        py_r     <= y0_a_s[sel_s];
                        busy_r   <= 1'b1;
                        if (sel_empty_s) begin
                            // Nothing to draw: straight to the done pulse.
                            state_r <= DONE;
                            done_r  <= sel_onehot_s;
                            pwe_r   <= 1'b0;
                        end else begin
                            state_r <= SWEEP;
                            done_r  <= '0;
                            pwe_r   <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SWEEP: begin
                    if (px_r < x1_r) begin
                        px_r <= px_r + W'(1);
                    end else if (py_r < y1_r) begin
                        px_r <= x0_r;
                        py_r <= py_r + W'(1);
                    end else begin
                        state_r <= DONE;
                        pwe_r   <= 1'b0;
                        done_r  <= grant_r;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= '0;
                    grant_r <= '0;
                    busy_r  <= 1'b0;
                    pwe_r   <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    done_r  <= '0;
                    grant_r <= '0;
                    busy_r  <= 1'b0;
                    pwe_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant  = grant_r;
    assign bus.done   = done_r;
    assign bus.busy   = busy_r;
    assign bus.px     = px_r;
    assign bus.py     = py_r;
    assign bus.pcolor = pcolor_r;
    assign bus.pwe    = pwe_r;

endmodule

// File: doc/draw_scheduler.md
# draw_scheduler

Round-robin scheduler that shares one rectangle-fill pixel engine among NREQ drawing requesters: bird sprite, pipe/ground column, full-screen clear, and future score overlay. It grants one requester at a time, latches that requester's rectangle and colour, and sweeps every pixel of the rectangle onto a single pixel-write port toward the VGA frame buffer. When the sweep finishes it pulses a per-requester done. The game FSM issues requests and waits for done instead of multiplexing several fill engines itself.

## Interface
Parameters:
- NREQ, 3, number of requesters; index 0 is first in line after reset.
- W, 11, coordinate width in bits.

Ports:
- clks  in  1  clock; all state changes on its rising edge.
- reset  in  1  reset, synchronous, active-high; clock clks.
- req  in  NREQ  per-requester draw request, level; must be held until the matching done.
- rx0  in  NREQ*W  per-requester left x; slice i is bits [i*W +: W]. Same packing applies to rx1, ry0 and ry1.
- rx1  in  NREQ*W  per-requester right x, inclusive.
- ry0  in  NREQ*W  per-requester top y.
- ry1  in  NREQ*W  per-requester bottom y, inclusive.
- rcolor  in  NREQ  per-requester pixel colour: 1 = white, 0 = black.
- grant  out  NREQ  one-hot owner of the engine; all zero when idle.
- done  out  NREQ  one-cycle pulse on the granted bit at job end.
- busy  out  1  high whenever state is not IDLE.
- px, py  out  W each  current pixel coordinate.
- pcolor  out  1  colour of the current pixel.
- pwe  out  1  pixel write strobe; px, py and pcolor are valid only when pwe = 1.

## Operation
- States: IDLE, SWEEP, DONE.
- Round-robin pointer `last` (index of the last granted requester) resets to NREQ-1, so req[0] wins first.
- Requester search order starts at last+1 and wraps modulo NREQ.
- IDLE, no req: stay in IDLE.
- IDLE, any req set: select the first set bit in search order as g.
  - Latch rx0/rx1/ry0/ry1/rcolor slice g.
  - Set grant = one-hot(g) and last = g.
  - Load px = x0, py = y0.
  - If x1 < x0 or y1 < y0 (unsigned compare): rectangle is empty; go to DONE and emit no pixels.
  - Otherwise go to SWEEP.
- SWEEP: pwe = 1 every cycle. Pixel order is row-major, x fastest:
  - px < x1: px = px + 1.
  - px == x1 and py < y1: px = x0, py = py + 1.
  - px == x1 and py == y1: this is the last pixel; go to DONE.
- DONE: done[g] = 1 and pwe = 0. Next state is IDLE, and grant clears on that edge.
- Coordinates and colour are latched once per job. Changes to the rx/ry/rcolor inputs or to req during a job have no effect on that job.
- Req deasserted mid-job: the job still completes and still pulses done.
- Req still held after done: the requester is eligible again in the next IDLE cycle, behind every other pending requester.
- Arithmetic: all comparisons unsigned in W bits. Counters never exceed the latched x1/y1, so no wrap is possible.
- When pwe = 0, px and py hold their last value.

## Timing
- Reset values: grant = 0, done = 0, busy = 0, px = 0, py = 0, pcolor = 0, pwe = 0, state = IDLE, last = NREQ-1.
- Reset asserted mid-job: every output takes its reset value at the next edge. The aborted requester gets no done.
- Latency: req sampled high in IDLE at edge k gives grant and the first pixel (pwe = 1) in cycle k+1.
- Job length: N = (x1-x0+1)*(y1-y0+1) pixel cycles, followed by 1 DONE cycle and 1 IDLE cycle.
- Back-to-back jobs are separated by exactly 2 cycles with pwe = 0 (DONE, then IDLE).
- Empty job: grant is set for the DONE cycle only; done pulses in cycle k+1 and pwe never goes high.
- Simultaneous requests: exactly one grant per IDLE decision. The others wait; no request is ever dropped.
- Invariant: grant is always one-hot or zero.
- Invariant: done is never set without the matching grant bit set in the same cycle.

## Test plan
- Single rectangle: req[0] with rectangle (10,20)-(11,21), colour 1 → pwe high for 4 cycles with px,py = (10,20), (11,20), (10,21), (11,21), pcolor = 1 throughout, then done[0] for 1 cycle.
- Fairness: after reset, req = 3'b111 held, every rectangle 1x1 → grant sequence 001, 010, 100, 001. Each job has 1 pixel and jobs are 3 cycles apart.
- Empty rectangle: req[1] with x0 = 5, x1 = 4 → pwe never high; done[1] pulses in cycle k+1.
- Reset mid-sweep: req[2] with a 0..639 x 0..479 clear, reset asserted at pixel 1000 → next cycle all outputs 0 and no done pulses.
- Full-screen clear: req[2] with rectangle (0,0)-(639,479) → exactly 307200 pwe cycles, last pixel (639,479), then done[2].
- Input change during job: vary rx0, ry1, rcolor and drop req[0] while job 0 runs → output pixels match the values latched at grant, and done[0] still pulses.
